link_writequeue: RTL and testbench

LINK_WRITEQUEUE -- requirements
Module: link_writequeue

---
 rtl/link_writequeue_pkg.sv | 28 ++
 rtl/link_writequeue_if.sv | 38 +++
 rtl/link_writequeue_fifo.sv | 63 ++++++
 rtl/link_writequeue.sv | 153 +++++++++++++++
 tb/tb_link_writequeue.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/link_writequeue_pkg.sv
// Shared definitions for the link write queue: entry control layout, packing helper,
// requester-side state encoding and boolean constants.
package link_pkg;

    localparam logic FALSE = 1'b0;
    localparam logic TRUE  = 1'b1;

    localparam int LEN_W = 3;

    // Entry layout, MSB to LSB: {address, data, ctrl}
    typedef struct packed {
        logic [LEN_W-1:0] length;
        logic             cache_disable;
        logic             write_through;
    } wq_ctrl_t;

    localparam int CTRL_W = $bits(wq_ctrl_t);

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_BUSY = 1'b1
    } req_state_e;

    function automatic int entry_w(input int addr_w, input int data_w);
        return CTRL_W + addr_w + data_w;
    endfunction

endpackage

// File: rtl/link_writequeue_if.sv
// Requester and cache-facing handshake bundle of the link write queue.
interface link_writequeue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import link_pkg::*;

    logic              req_do;
    logic              req_done;
    logic [LEN_W-1:0]  req_length;
    logic              req_cache_disable;
    logic [ADDR_W-1:0] req_address;
    logic              req_write_through;
    logic [DATA_W-1:0] req_data;

    logic              resp_do;
    logic              resp_done;
    logic [LEN_W-1:0]  resp_length;
    logic              resp_cache_disable;
    logic [ADDR_W-1:0] resp_address;
    logic              resp_write_through;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_do, req_length, req_cache_disable, req_address, req_write_through, req_data,
        output resp_done,
        input  req_done,
        input  resp_do, resp_length, resp_cache_disable, resp_address, resp_write_through, resp_data
    );

    modport slave (
        input  req_do, req_length, req_cache_disable, req_address, req_write_through, req_data,
        input  resp_done,
        output req_done,
        output resp_do, resp_length, resp_cache_disable, resp_address, resp_write_through, resp_data
    );

endinterface

// File: rtl/link_writequeue_fifo.sv
// Entry storage for the write queue: circular buffer with per-slot valid bits so the
// hazard logic can inspect every queued entry.
module link_wq_fifo
    import link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [W-1:0]                  push_data,
    input  logic                          pop,
    output logic [W-1:0]                  head,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0][W-1:0]       entries,
    output logic [DEPTH-1:0]              valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][W-1:0] mem_r;
    logic [DEPTH-1:0]        valid_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    push_ok_s;
    logic                    pop_ok_s;

    assign push_ok_s = push & (count_r != CNT_W'(DEPTH));
    assign pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});

    // Storage, pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= '0;
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r]   <= push_data;
                valid_r[wr_ptr_r] <= TRUE;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                valid_r[rd_ptr_r] <= FALSE;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    assign head    = mem_r[rd_ptr_r];
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;
    assign entries = mem_r;
    assign valid   = valid_r;

endmodule

// File: rtl/link_writequeue.sv
// Write queue between a requester and the cache: accepts one write per request handshake,
// presents entries in FIFO order and flags reads that overlap a queued write.
module link_writequeue
    import link_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int POSTED = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    link_writequeue_if.slave       bus,
    input  logic [ADDR_W-1:0]      rd_address,
    output logic                   rd_conflict,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);

    req_state_e                    state_r;
    req_state_e                    state_nxt_s;
    logic                          enq_s;
    logic                          done_set_s;
    logic                          req_done_r;
    logic                          pop_s;
    logic                          full_s;
    logic                          empty_s;
    logic                          conflict_s;
    logic [CNT_W-1:0]              count_s;
    wq_ctrl_t                      req_ctrl_s;
    wq_ctrl_t                      head_ctrl_s;
    logic [ENTRY_W-1:0]            push_data_s;
    logic [ENTRY_W-1:0]            head_s;
    logic [DEPTH-1:0][ENTRY_W-1:0] entries_s;
    logic [DEPTH-1:0]              valid_s;

    // Does a queued entry touch the same dword as the read, at its first or last byte
    function automatic logic entry_hits(input logic [ENTRY_W-1:0] e, input logic [ADDR_W-1:0] rd);
        wq_ctrl_t          c;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] last;
        c    = wq_ctrl_t'(e[CTRL_W-1:0]);
        a    = e[ENTRY_W-1 -: ADDR_W];
        last = a + ADDR_W'(c.length) - ADDR_W'(1);
        return (a[ADDR_W-1:2] == rd[ADDR_W-1:2]) || (last[ADDR_W-1:2] == rd[ADDR_W-1:2]);
    endfunction

    assign full_s = (count_s == CNT_W'(DEPTH));
    assign pop_s  = bus.resp_done & ~empty_s;

    // Accepted-flag state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= REQ_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accepted-flag next state: set on enqueue, cleared by the done pulse
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            REQ_IDLE: begin
                if (bus.req_do && !full_s) state_nxt_s = REQ_BUSY;
                else                       state_nxt_s = REQ_IDLE;
            end
            REQ_BUSY: begin
                if (req_done_r) state_nxt_s = REQ_IDLE;
                else            state_nxt_s = REQ_BUSY;
            end
            default: state_nxt_s = REQ_IDLE;
        endcase
    end

    // Enqueue strobe and done request; non-posted waits for its own entry to pop
    always_comb begin
        enq_s      = FALSE;
        done_set_s = FALSE;
        case (state_r)
            REQ_IDLE: begin
                enq_s      = bus.req_do & ~full_s;
                done_set_s = (POSTED != 0) ? (bus.req_do & ~full_s) : FALSE;
            end
            REQ_BUSY: begin
                enq_s      = FALSE;
                done_set_s = (POSTED != 0) ? FALSE : pop_s;
            end
            default: begin
                enq_s      = FALSE;
                done_set_s = FALSE;
            end
        endcase
    end

    // Registered one-cycle completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_done_r <= FALSE;
        end else begin
            req_done_r <= done_set_s;
        end
    end

    // Pack the request into the entry layout
    always_comb begin
        req_ctrl_s               = '0;
        req_ctrl_s.length        = bus.req_length;
        req_ctrl_s.cache_disable = bus.req_cache_disable;
        req_ctrl_s.write_through = bus.req_write_through;
        push_data_s              = {bus.req_address, bus.req_data, req_ctrl_s};
    end

    link_wq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .count     (count_s),
        .entries   (entries_s),
        .valid     (valid_s)
    );

    // Read-after-write hazard across all valid entries
    always_comb begin
        conflict_s = FALSE;
        for (int i = 0; i < DEPTH; i++) begin
            conflict_s = conflict_s | (valid_s[i] & entry_hits(entries_s[i], rd_address));
        end
    end

    assign head_ctrl_s            = wq_ctrl_t'(head_s[CTRL_W-1:0]);
    assign bus.req_done           = req_done_r;
    assign bus.resp_do            = ~empty_s;
    assign bus.resp_address       = head_s[ENTRY_W-1 -: ADDR_W];
    assign bus.resp_data          = head_s[CTRL_W +: DATA_W];
    assign bus.resp_length        = head_ctrl_s.length;
    assign bus.resp_cache_disable = head_ctrl_s.cache_disable;
    assign bus.resp_write_through = head_ctrl_s.write_through;
    assign rd_conflict            = conflict_s;
    assign empty                  = empty_s;
    assign count                  = count_s;

endmodule

// File: tb/tb_link_writequeue.sv
// Directed scoreboard bench for link_writequeue: posted instance for queueing, ordering,
// hazards and reset; non-posted instance for completion timing.
module tb_link_writequeue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rd_address = '0;
    logic        rd_conflict, empty, rd_conflict_np, empty_np;
    logic [2:0]  count, count_np;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  l;
    } exp_t;
    exp_t sb[$];

    link_writequeue_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    link_writequeue_if #(.ADDR_W(32), .DATA_W(32)) bus_np ();

    link_writequeue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .POSTED(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .rd_address(rd_address),
        .rd_conflict(rd_conflict), .empty(empty), .count(count)
    );

    link_writequeue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .POSTED(0)) dut_np (
        .clk(clk), .rst_n(rst_n), .bus(bus_np.slave), .rd_address(rd_address),
        .rd_conflict(rd_conflict_np), .empty(empty_np), .count(count_np)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
        bus.req_address       = a;
        bus.req_data          = d;
        bus.req_length        = l;
        bus.req_cache_disable = d[0];
        bus.req_write_through = d[1];
        bus.req_do            = 1'b1;
        sb.push_back('{a: a, d: d, l: l});
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l,
                            input int exp_lat, input string tag);
        int lat;
        set_req(a, d, l);
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.req_done !== 1'b1 && lat < 40);
        check({tag, "_done_lat"}, 64'(lat), 64'(exp_lat));
        bus.req_do = 1'b0;
    endtask

    task automatic drain_one(input string tag);
        exp_t e;
        e = '{a: 32'h0, d: 32'h0, l: 3'h0};
        if (sb.size() > 0) e = sb.pop_front();
        check({tag, "_resp_do"}, 64'(bus.resp_do), 64'h1);
        check({tag, "_resp_addr"}, 64'(bus.resp_address), 64'(e.a));
        check({tag, "_resp_data"}, 64'(bus.resp_data), 64'(e.d));
        check({tag, "_resp_len"}, 64'(bus.resp_length), 64'(e.l));
        check({tag, "_resp_cd_wt"}, 64'({bus.resp_write_through, bus.resp_cache_disable}),
              64'(e.d[1:0]));
        bus.resp_done = 1'b1;
        step();
        bus.resp_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_done"}, 64'(bus.req_done), 64'h0);
        check({tag, "_resp_do"}, 64'(bus.resp_do), 64'h0);
        check({tag, "_resp_addr"}, 64'(bus.resp_address), 64'h0);
        check({tag, "_resp_data"}, 64'(bus.resp_data), 64'h0);
        check({tag, "_resp_len"}, 64'(bus.resp_length), 64'h0);
        check({tag, "_rd_conflict"}, 64'(rd_conflict), 64'h0);
        check({tag, "_empty"}, 64'(empty), 64'h1);
        check({tag, "_count"}, 64'(count), 64'h0);
    endtask

    initial begin
        bus.req_do = 1'b0; bus.req_address = '0; bus.req_data = '0; bus.req_length = '0;
        bus.req_cache_disable = 1'b0; bus.req_write_through = 1'b0; bus.resp_done = 1'b0;
        bus_np.req_do = 1'b0; bus_np.req_address = '0; bus_np.req_data = '0; bus_np.req_length = '0;
        bus_np.req_cache_disable = 1'b0; bus_np.req_write_through = 1'b0; bus_np.resp_done = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        rd_address = 32'h0000_1000;
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // single posted write
        do_write(32'h0000_1000, 32'hDEAD_BEEF, 3'd4, 1, "single");
        check("single_resp_do_lat", 64'(bus.resp_do), 64'h1);
        check("single_count", 64'(count), 64'h1);
        step();
        check("single_done_one_pulse", 64'(bus.req_done), 64'h0);
        drain_one("single");
        check("single_empty", 64'(empty), 64'h1);

        // fill to DEPTH, then stall a fifth request until one pop
        do_write(32'h0000_0100, 32'hA000_0001, 3'd4, 1, "fill0");
        do_write(32'h0000_0200, 32'hA000_0002, 3'd4, 2, "fill1");
        do_write(32'h0000_0300, 32'hA000_0003, 3'd4, 2, "fill2");
        do_write(32'h0000_0400, 32'hA000_0004, 3'd4, 2, "fill3");
        check("full_count", 64'(count), 64'h4);
        set_req(32'h0000_0500, 32'hA000_0005, 3'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_no_done", 64'(bus.req_done), 64'h0);
            check("stall_count", 64'(count), 64'h4);
        end
        drain_one("stall_pop");
        check("after_pop_count", 64'(count), 64'h3);
        check("after_pop_no_done", 64'(bus.req_done), 64'h0);
        step();
        check("fifth_done", 64'(bus.req_done), 64'h1);
        check("fifth_count", 64'(count), 64'h4);
        bus.req_do = 1'b0;
        for (int i = 0; i < 4; i++) drain_one("fill_drain");
        check("fill_empty", 64'(empty), 64'h1);

        // FIFO order across pointer wrap: 3 + 3 + 2 writes
        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r < 2) ? 3 : 2;
            for (int k = 0; k < n; k++)
                do_write(32'h10 * (k + 1), 32'hB000_0000 + 32'(r * 4 + k), 3'd4, (k == 0) ? 1 : 2, "order");
            check("order_count", 64'(count), 64'(n));
            for (int k = 0; k < n; k++) drain_one("order");
        end

        // simultaneous enqueue and pop
        do_write(32'h0000_0040, 32'hC000_0001, 3'd2, 1, "simul0");
        step();
        set_req(32'h0000_0050, 32'hC000_0002, 3'd1);
        drain_one("simul_pop");
        check("simul_count", 64'(count), 64'h1);
        check("simul_done", 64'(bus.req_done), 64'h1);
        bus.req_do = 1'b0;
        step();
        drain_one("simul_tail");
        check("simul_empty", 64'(empty), 64'h1);

        // read hazard against a queued write spanning a dword boundary
        do_write(32'h0000_1003, 32'hD000_0003, 3'd2, 1, "haz");
        rd_address = 32'h0000_1004; #1;
        check("haz_last_dword", 64'(rd_conflict), 64'h1);
        rd_address = 32'h0000_1008; #1;
        check("haz_miss", 64'(rd_conflict), 64'h0);
        rd_address = 32'h0000_1000; #1;
        check("haz_first_dword", 64'(rd_conflict), 64'h1);
        drain_one("haz");
        rd_address = 32'h0000_1004; #1;
        check("haz_after_pop_1004", 64'(rd_conflict), 64'h0);
        rd_address = 32'h0000_1008; #1;
        check("haz_after_pop_1008", 64'(rd_conflict), 64'h0);

        // non-posted: done one cycle after resp_done pops the entry
        bus_np.req_address = 32'h0000_2000; bus_np.req_data = 32'h1234_5678;
        bus_np.req_length = 3'd4; bus_np.req_do = 1'b1;
        step();
        check("np_resp_do", 64'(bus_np.resp_do), 64'h1);
        check("np_resp_addr", 64'(bus_np.resp_address), 64'h2000);
        check("np_resp_data", 64'(bus_np.resp_data), 64'h1234_5678);
        check("np_no_early_done", 64'(bus_np.req_done), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("np_wait_no_done", 64'(bus_np.req_done), 64'h0);
            check("np_single_entry", 64'(count_np), 64'h1);
        end
        bus_np.resp_done = 1'b1;
        step();
        bus_np.resp_done = 1'b0;
        check("np_done", 64'(bus_np.req_done), 64'h1);
        check("np_empty", 64'(empty_np), 64'h1);
        bus_np.req_do = 1'b0;
        step();
        check("np_done_one_pulse", 64'(bus_np.req_done), 64'h0);

        // reset with three entries queued and a done pulse in flight
        do_write(32'h0000_3000, 32'hE000_0001, 3'd4, 1, "rq0");
        do_write(32'h0000_3010, 32'hE000_0002, 3'd4, 2, "rq1");
        do_write(32'h0000_3020, 32'hE000_0003, 3'd4, 2, "rq2");
        check("rq_count", 64'(count), 64'h3);
        rd_address = 32'h0000_3000;
        #1;
        check("rq_conflict_before", 64'(rd_conflict), 64'h1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_done", 64'(bus.req_done), 64'h0);
            check("post_rst_empty", 64'(empty), 64'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
